// File: rtl/irq_request_latch.sv
// Interrupt request latch: per-channel edge/level capture with freeze, per-channel clear and masked priority select.
// Optional IRQ_SYNC_EN macro inserts a two-flop synchroniser on every request pin.
module irq_request_latch #(
    parameter int NUM_IRQ = 8,
    parameter int ID_W    = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] interrupt_req_pin,
    input  logic [NUM_IRQ-1:0] level_mode,
    input  logic               freeze,
    input  logic [NUM_IRQ-1:0] clear_interrupt_req,
    input  logic [NUM_IRQ-1:0] interrupt_mask,
    output logic [NUM_IRQ-1:0] interrupt_req_register,
    output logic               req_valid,
    output logic [ID_W-1:0]    req_id
);

    logic [NUM_IRQ-1:0] pin_s;
    logic [NUM_IRQ-1:0] pin_prev_p1;
    logic [NUM_IRQ-1:0] pend_p1;
    logic [NUM_IRQ-1:0] edge_evt;
    logic [NUM_IRQ-1:0] reg_base;
    logic [NUM_IRQ-1:0] reg_nxt;
    logic [NUM_IRQ-1:0] pend_nxt;
    logic [NUM_IRQ-1:0] active;

`ifdef IRQ_SYNC_EN
    logic [NUM_IRQ-1:0] pin_sync_p0;
    logic [NUM_IRQ-1:0] pin_sync_p1;

    // Stage p0/p1: metastability guard for the asynchronous request lines
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pin_sync_p0 <= '0;
            pin_sync_p1 <= '0;
        end else begin
            pin_sync_p0 <= interrupt_req_pin;
            pin_sync_p1 <= pin_sync_p0;
        end
    end

    assign pin_s = pin_sync_p1;
`else
    assign pin_s = interrupt_req_pin;
`endif

    // Clear wins over everything, including freeze and a coincident edge
    always_comb begin
        edge_evt = pin_s & ~pin_prev_p1 & ~level_mode;
        reg_base = (level_mode & pin_s) | (~level_mode & interrupt_req_register);
        reg_nxt  = interrupt_req_register;
        pend_nxt = pend_p1;
        if (freeze) begin
            reg_nxt  = interrupt_req_register & ~clear_interrupt_req;
            pend_nxt = (pend_p1 | edge_evt) & ~clear_interrupt_req;
        end else begin
            reg_nxt  = (reg_base | pend_p1 | edge_evt) & ~clear_interrupt_req;
            pend_nxt = '0;
        end
    end

    // Stage p1: latched request state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            interrupt_req_register <= '0;
            pend_p1                <= '0;
            pin_prev_p1            <= '0;
        end else begin
            interrupt_req_register <= reg_nxt;
            pend_p1                <= pend_nxt;
            pin_prev_p1            <= pin_s;
        end
    end

    assign active    = interrupt_req_register & ~interrupt_mask;
    assign req_valid = |active;

    // Scan downwards so the lowest active index is the last (winning) assignment
    always_comb begin
        req_id = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (active[i]) begin
                req_id = i[ID_W-1:0];
            end
        end
    end

endmodule
